// File: rtl/fp32_div_iter.sv
// Iterative fp32 divider (out = a / b): restoring division retiring BITS_PER_CYCLE quotient bits per cycle.
// Define FP32_DIV_ROUND_EN for round-to-nearest-even; the default build truncates like the mul/add units.
//
// state | meaning
// IDLE  | waiting for next; in_ready high
// PREP  | align significands, form biased exponent
// DIV   | restoring division, BITS_PER_CYCLE quotient bits per cycle
// PACK  | special-case priority, range check, write out
module fp32_div_iter #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        next,
    output logic        in_ready,
    output logic [31:0] out,
    output logic        next_out
);
    localparam int LATENCY = 24 / BITS_PER_CYCLE + 3;
    localparam logic [4:0] DIV_LOAD = 5'(LATENCY - 4);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PREP = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] PACK = 2'd3;

    generate
        if (BITS_PER_CYCLE < 1 || BITS_PER_CYCLE > 4) begin : gBadBitsPerCycle
            $error("fp32_div_iter: BITS_PER_CYCLE must be 1, 2, 3 or 4");
        end
    endgenerate

    logic [1:0]        state;
    logic [31:0]       opA;
    logic [31:0]       opB;
    logic [25:0]       rem;
    logic [25:0]       remNext;
    logic [22:0]       quo;
    logic [22:0]       quoNext;
    logic signed [9:0] expAcc;
    logic signed [9:0] expFinal;
    logic [22:0]       manFinal;
    logic [4:0]        divCnt;
    logic [31:0]       result;

    logic [23:0] sigA;
    logic [23:0] sigB;
    logic        sign;
    logic        aZero, aInf, aNan;
    logic        bZero, bInf, bNan;

    assign in_ready = (state == IDLE);

    assign sigA = {1'b1, opA[22:0]};
    assign sigB = {1'b1, opB[22:0]};
    assign sign = opA[31] ^ opB[31];

    assign aZero = (opA[30:23] == 8'h00);
    assign aInf  = (opA[30:23] == 8'hff) && (opA[22:0] == 23'd0);
    assign aNan  = (opA[30:23] == 8'hff) && (opA[22:0] != 23'd0);
    assign bZero = (opB[30:23] == 8'h00);
    assign bInf  = (opB[30:23] == 8'hff) && (opB[22:0] == 23'd0);
    assign bNan  = (opB[30:23] == 8'hff) && (opB[22:0] != 23'd0);

    // rem always holds twice the true partial remainder, so it stays below 2*sigB
    always_comb begin
        remNext = rem;
        quoNext = quo;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (remNext >= {2'b00, sigB}) begin
                remNext = (remNext - {2'b00, sigB}) << 1;
                quoNext = {quoNext[21:0], 1'b1};
            end else begin
                remNext = remNext << 1;
                quoNext = {quoNext[21:0], 1'b0};
            end
        end
    end

`ifdef FP32_DIV_ROUND_EN
    logic        roundUp;
    logic [23:0] quoRnd;
`endif

    always_comb begin
        expFinal = expAcc;
        manFinal = quo;
`ifdef FP32_DIV_ROUND_EN
        roundUp  = (rem >= {2'b00, sigB}) &&
                   (((rem != {2'b00, sigB}) && (rem != 26'd0)) || quo[0]);
        quoRnd   = {1'b0, quo} + {23'd0, roundUp};
        manFinal = quoRnd[22:0];
        expFinal = expAcc + $signed({9'd0, quoRnd[23]});
`endif
        if (aNan || bNan || (aZero && bZero) || (aInf && bInf)) begin
            result = {sign, 8'hff, 23'd1};
        end else if (aInf || bZero) begin
            result = {sign, 8'hff, 23'd0};
        end else if (aZero || bInf) begin
            result = {sign, 8'h00, 23'd0};
        end else if (expFinal >= 10'sd255) begin
            result = {sign, 8'hff, 23'd0};
        end else if (expFinal <= 10'sd0) begin
            result = {sign, 8'h00, 23'd0};
        end else begin
            result = {sign, expFinal[7:0], manFinal};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            out      <= 32'd0;
            next_out <= 1'b0;
            opA      <= 32'd0;
            opB      <= 32'd0;
            rem      <= 26'd0;
            quo      <= 23'd0;
            expAcc   <= 10'sd0;
            divCnt   <= 5'd0;
        end else begin
            next_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (next) begin
                        opA   <= a;
                        opB   <= b;
                        state <= PREP;
                    end
                end
                PREP: begin
                    // pre-shift keeps the quotient MSB at 1
                    if (sigA < sigB) begin
                        rem    <= {1'b0, sigA, 1'b0};
                        expAcc <= $signed({2'b00, opA[30:23]}) - $signed({2'b00, opB[30:23]}) + 10'sd126;
                    end else begin
                        rem    <= {2'b00, sigA};
                        expAcc <= $signed({2'b00, opA[30:23]}) - $signed({2'b00, opB[30:23]}) + 10'sd127;
                    end
                    quo    <= 23'd0;
                    divCnt <= DIV_LOAD;
                    state  <= DIV;
                end
                DIV: begin
                    rem <= remNext;
                    quo <= quoNext;
                    if (divCnt == 5'd0) begin
                        state <= PACK;
                    end else begin
                        divCnt <= divCnt - 5'd1;
                    end
                end
                PACK: begin
                    out      <= result;
                    next_out <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp32_div_iter.sv
// Scoreboard bench for fp32_div_iter: BITS_PER_CYCLE=1 instance for values, handshake and reset,
// plus a BITS_PER_CYCLE=4 instance for the short-latency case.
module tb_fp32_div_iter;
    localparam int LATENCY  = 27;
    localparam int LATENCY4 = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a, b, out;
    logic        next, in_ready, next_out;
    logic [31:0] a4, b4, out4;
    logic        next4, inReady4, nextOut4;

    typedef struct {
        logic [31:0] expOut;
        int          acc;
    } sbItem_t;

    sbItem_t     sb[$];
    sbItem_t     item;
    int          edgeCnt = 0;
    int          tests   = 0;
    int          fails   = 0;
    logic [31:0] lastOut = 32'd0;
    logic        checkHold = 1'b0;

    fp32_div_iter #(.BITS_PER_CYCLE(1)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .next(next),
        .in_ready(in_ready), .out(out), .next_out(next_out)
    );

    fp32_div_iter #(.BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset(reset), .a(a4), .b(b4), .next(next4),
        .in_ready(inReady4), .out(out4), .next_out(nextOut4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // cycle k of an op is the clock period ending at edge acc+k
    always @(negedge clk) begin
        if (next_out) begin
            if (sb.size() == 0) begin
                checkVal("spurious_next_out", {31'd0, next_out}, 32'd0);
            end else begin
                item = sb.pop_front();
                checkVal("out", out, item.expOut);
                checkVal("latency", 32'(edgeCnt + 1 - item.acc), 32'(LATENCY));
                checkVal("in_ready_at_done", {31'd0, in_ready}, 32'd1);
            end
            lastOut = out;
        end else if (checkHold) begin
            checkVal("out_hold", out, lastOut);
        end
    end

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] exp,
                         output int acc);
        checkVal("ready_before_issue", {31'd0, in_ready}, 32'd1);
        a    = ia;
        b    = ib;
        next = 1'b1;
        acc  = edgeCnt + 1;
        sb.push_back('{exp, acc});
        @(negedge clk);
        next = 1'b0;
        a    = 32'hdead_beef;
        b    = 32'hdead_beef;
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (sb.size() != 0) begin
            checkVal("timeout_pending", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic waitToCycle(input int acc, input int k);
        while (edgeCnt + 1 - acc < k) @(negedge clk);
    endtask

    task automatic runOp(input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] exp);
        int acc;
        issue(ia, ib, exp, acc);
        waitDone(LATENCY + 10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2;
        int seen;
        logic [31:0] oneThird;

`ifdef FP32_DIV_ROUND_EN
        oneThird = 32'h3EAAAAAB;
`else
        oneThird = 32'h3EAAAAAA;
`endif
        reset = 1'b0;
        next  = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        next4 = 1'b0;
        a4    = 32'd0;
        b4    = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        checkVal("rst_out", out, 32'd0);
        checkVal("rst_next_out", {31'd0, next_out}, 32'd0);
        checkVal("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkVal("rst_out4", out4, 32'd0);
        checkVal("rst_in_ready4", {31'd0, inReady4}, 32'd1);
        checkHold = 1'b1;

        runOp(32'h40C00000, 32'h40000000, 32'h40400000);
        runOp(32'h3F800000, 32'h40400000, oneThird);
        runOp(32'h3F800000, 32'h00000000, 32'h7F800000);
        runOp(32'h00000000, 32'h00000000, 32'h7F800001);
        runOp(32'hBF800000, 32'h7F800000, 32'h80000000);
        runOp(32'h7FC00000, 32'h3F800000, 32'h7F800001);
        runOp(32'h7F000000, 32'h00800000, 32'h7F800000);
        runOp(32'h00800000, 32'h7F000000, 32'h00000000);
        runOp(32'h00000001, 32'h3F800000, 32'h00000000);
        runOp(32'h7F800000, 32'hFF800000, 32'hFF800001);
        runOp(32'hC1000000, 32'h40000000, 32'hC0800000);
        runOp(32'h40E00000, 32'h40000000, 32'h40600000);
        runOp(32'hBF800000, 32'h00000000, 32'hFF800000);

        // strobes at cycles 0, 5 and 27: the cycle-5 one must be dropped
        issue(32'h40C00000, 32'h40000000, 32'h40400000, acc);
        waitToCycle(acc, 5);
        checkVal("busy_in_ready", {31'd0, in_ready}, 32'd0);
        a    = 32'h3F800000;
        b    = 32'h40400000;
        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        waitToCycle(acc, LATENCY);
        issue(32'h40E00000, 32'h40000000, 32'h40600000, acc2);
        checkVal("b2b_accept_cycle", 32'(acc2 - acc), 32'(LATENCY));
        waitDone(LATENCY + 10);

        // reset at cycle 10 aborts the op with no next_out
        issue(32'h40C00000, 32'h40000000, 32'h40400000, acc);
        waitToCycle(acc, 10);
        reset     = 1'b0;
        checkHold = 1'b0;
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        checkVal("abort_out", out, 32'd0);
        checkVal("abort_in_ready", {31'd0, in_ready}, 32'd1);
        checkVal("abort_next_out", {31'd0, next_out}, 32'd0);
        lastOut   = 32'd0;
        checkHold = 1'b1;
        repeat (2 * LATENCY) @(negedge clk);
        runOp(32'h40E00000, 32'h40000000, 32'h40600000);

        // BITS_PER_CYCLE=4 instance
        a4    = 32'h40C00000;
        b4    = 32'h40000000;
        next4 = 1'b1;
        acc   = edgeCnt + 1;
        @(negedge clk);
        next4 = 1'b0;
        seen  = 0;
        for (int n = 0; n < 3 * LATENCY4 && seen == 0; n++) begin
            if (nextOut4) begin
                seen = 1;
                checkVal("bpc4_latency", 32'(edgeCnt + 1 - acc), 32'(LATENCY4));
                checkVal("bpc4_out", out4, 32'h40400000);
                checkVal("bpc4_in_ready", {31'd0, inReady4}, 32'd1);
            end else begin
                @(negedge clk);
            end
        end
        if (seen == 0) checkVal("bpc4_timeout", {31'd0, nextOut4}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fp32_div_iter.md
Name: fp32_div_iter

Overview:
- Iterative single-precision floating-point divider, out = a / b.
- Arithmetic rules match the existing pipelined fp32 multiply and add units: denormals flush to zero, NaN is encoded as {sign, 8'hff, 23'd1}, and results are truncated by default.
- Fixed-latency handshake with a `next` strobe in and a `next_out` strobe out, compatible with the complex arithmetic datapath control.
- Used ahead of complex division and normalisation stages, where the area of a fully pipelined divider is not justified.

Parameters:
- BITS_PER_CYCLE, default 1: quotient bits retired per DIV cycle. Legal values are 1, 2, 3, 4; anything else is an elaboration error.
- LATENCY, derived, = 24/BITS_PER_CYCLE + 3: cycles from accept to `next_out`. Not overridable.

Ports:
- clk, input, 1: clock.
- reset, input, 1: reset, synchronous and active-low (asserted when 0).
- a, input, 32: dividend, IEEE-754 fp32.
- b, input, 32: divisor, IEEE-754 fp32.
- next, input, 1: operand strobe; accepted only when in_ready=1.
- in_ready, output, 1: high in IDLE.
- out, output, 32: quotient; holds its value until the next result.
- next_out, output, 1: one-cycle pulse when `out` is updated.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state goes to IDLE; out=0, next_out=0, in_ready=1 after the edge.
  - Reset mid-operation aborts with no `next_out`.
- States: IDLE → PREP → DIV → PACK → IDLE.
- IDLE:
  - A clk edge with next=1 latches a and b and moves to PREP.
  - Accept edge = cycle 0; in_ready drops after that edge.
- PREP (1 cycle): classify and align.
  - Classify each operand: zero = exp==0 (mantissa ignored); inf = exp==ff, man==0; nan = exp==ff, man!=0.
  - Sign = sa ^ sb, for all result types including NaN.
  - Significands: sigA={1,manA}, sigB={1,manB}.
  - If sigA < sigB: shift dividend left 1 and set e = ea − eb + 126; otherwise e = ea − eb + 127.
  - e is a 10-bit signed value.
- DIV (24/BITS_PER_CYCLE cycles):
  - Restoring division, 24 quotient bits total.
  - Remainder width is 26 bits; the quotient MSB is always 1.
- PACK (1 cycle): priority order, first match wins:
  1. NaN in either operand, 0/0, or inf/inf → {s, ff, 1}.
  2. inf/x or x/0 → {s, ff, 0}.
  3. 0/x or x/inf → {s, 00, 0}.
  4. e ≥ 255 → inf.
  5. e ≤ 0 → {s, 00, 0} (no denormals).
  6. Otherwise → {s, e[7:0], q[22:0]}.
- Timing:
  - Special cases run the full latency; there is no early exit.
  - `out` updates and next_out=1 at cycle LATENCY (27 for BITS_PER_CYCLE=1).
  - in_ready=1 in the same cycle as next_out.
  - With next=1 at that edge, the new op is accepted; back-to-back throughput is one op per LATENCY cycles.
- next=1 while in_ready=0 is ignored: no queueing and no error.
- a and b are don't-care outside the accept edge.

Optional Feature:
- Macro: FP32_DIV_ROUND_EN.
- Defined: round-to-nearest-even in PACK.
  - guard = (2·remainder ≥ divisor); sticky = (2·remainder ≠ divisor) && remainder ≠ 0.
  - Increment when guard && (sticky || q[0]).
  - A mantissa carry-out increments e; e reaching 255 gives inf.
  - Latency is unchanged.
- Undefined: truncation, bit-compatible with the multiply and add units.

Test Plan:
- 6.0 / 2.0 (0x40C00000 / 0x40000000), BITS_PER_CYCLE=1, accept at cycle 0 → out=0x40400000 with next_out=1 exactly at cycle 27.
- 1.0 / 3.0 (0x3F800000 / 0x40400000) → 0x3EAAAAAA without the macro; 0x3EAAAAAB with FP32_DIV_ROUND_EN.
- Special cases, each at latency 27:
  - 0x3F800000 / 0x00000000 → 0x7F800000.
  - 0 / 0 → 0x7F800001.
  - 0xBF800000 / 0x7F800000 → 0x80000000.
  - 0x7FC00000 / 1.0 → 0x7F800001.
- Range limits:
  - 0x7F000000 / 0x00800000 → 0x7F800000 (overflow).
  - 0x00800000 / 0x7F000000 → 0x00000000 (underflow).
  - 0x00000001 (denormal) / 1.0 → 0x00000000.
- Handshake:
  - Strobe `next` at cycles 0, 5 and 27 → only the cycle-0 and cycle-27 ops execute; next_out at cycles 27 and 54.
  - `out` holds its value between pulses.
- Reset:
  - reset=0 at cycle 10 of an op → no next_out ever for that op; out=0; in_ready=1 after the reset edge.
  - A new op accepted after reset releases completes normally.
  - Repeat the first scenario with BITS_PER_CYCLE=4 → next_out at cycle 9.
